// File: rtl/mips_instr_encoder_pkg.sv
// rtl/mips_instr_encoder_pkg.sv - shared kinds, opcodes, field positions and word classifier
package mips_instr_encoder_pkg;

  typedef enum logic [1:0] {
    KIND_R   = 2'b00,
    KIND_I   = 2'b01,
    KIND_J   = 2'b10,
    KIND_RSV = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    CLS_R = 2'd0,
    CLS_I = 2'd1,
    CLS_J = 2'd2
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int OP_W      = 6;
  localparam int REG_W     = 5;

  // Takes the opcode field of a word; the same rule the downstream classifier applies.
  function automatic cls_e classify(input logic [OP_W-1:0] op);
    if (op == OP_RTYPE)                 return CLS_R;
    else if (op == OP_J || op == OP_JAL) return CLS_J;
    else                                return CLS_I;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_enc_fifo.sv
// rtl/mips_instr_encoder_enc_fifo.sv - synchronous FIFO; head word reads as zero while empty
module enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_W'(1);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - MIPS R/I/J word assembler with output FIFO and per-class emit counters
// Optional destination-register usage counters enabled by ENC_REGUSE_EN.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [5:0]       req_op,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_shamt,
  input  logic [5:0]       req_funct,
  input  logic [15:0]      req_imm,
  input  logic [25:0]      req_target,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] cnt_j,
  output logic [CNT_W-1:0] err_cnt
`ifdef ENC_REGUSE_EN
  ,
  output logic [CNT_W-1:0] cnt_reg3,
  output logic [CNT_W-1:0] cnt_reg4,
  output logic [CNT_W-1:0] cnt_reg5,
  output logic [CNT_W-1:0] cnt_reg6
`endif
);

  logic [31:0]            enc_word;
  logic                   legal;
  logic                   accept;
  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  cls_e                   head_cls;

  logic [CNT_W-1:0] cnt_r_q, cnt_r_d, cnt_i_q, cnt_i_d, cnt_j_q, cnt_j_d, err_q, err_d;

  always_comb begin
    enc_word = '0;
    legal    = 1'b0;
    case (kind_e'(req_kind))
      KIND_R: begin
        enc_word = {OP_RTYPE, req_rs, req_rt, req_rd, req_shamt, req_funct};
        legal    = 1'b1;
      end
      KIND_I: begin
        enc_word = {req_op, req_rs, req_rt, req_imm};
        legal    = !(req_op == OP_RTYPE || req_op == OP_J || req_op == OP_JAL);
      end
      KIND_J: begin
        enc_word = {req_op, req_target};
        legal    = (req_op == OP_J || req_op == OP_JAL);
      end
      default: begin
        enc_word = '0;
        legal    = 1'b0;
      end
    endcase
  end

  // No bypass: a full FIFO refuses requests even while it is being popped.
  assign req_ready   = !rst && !fifo_full;
  assign accept      = req_valid && req_ready;
  assign fifo_push   = accept && legal;
  assign fifo_pop    = instr_ready && !fifo_empty;
  assign instr_valid = (fifo_count != '0);

  enc_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (enc_word),
    .rdata (instr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_cls = classify(instr[OP_LSB +: OP_W]);

  always_comb begin
    cnt_r_d = cnt_r_q;
    cnt_i_d = cnt_i_q;
    cnt_j_d = cnt_j_q;
    err_d   = err_q;
    if (accept && !legal) err_d = err_q + CNT_W'(1);
    if (fifo_pop) begin
      case (head_cls)
        CLS_R:   cnt_r_d = cnt_r_q + CNT_W'(1);
        CLS_J:   cnt_j_d = cnt_j_q + CNT_W'(1);
        default: cnt_i_d = cnt_i_q + CNT_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r_q <= '0;
      cnt_i_q <= '0;
      cnt_j_q <= '0;
      err_q   <= '0;
    end else begin
      cnt_r_q <= cnt_r_d;
      cnt_i_q <= cnt_i_d;
      cnt_j_q <= cnt_j_d;
      err_q   <= err_d;
    end
  end

  assign cnt_r   = cnt_r_q;
  assign cnt_i   = cnt_i_q;
  assign cnt_j   = cnt_j_q;
  assign err_cnt = err_q;

`ifdef ENC_REGUSE_EN
  logic [3:0][CNT_W-1:0] reg_cnt_q, reg_cnt_d;
  logic [REG_W-1:0]      dst_reg;
  logic                  has_dst;

  // Destination is rd for R words, rt for I words; J words have none.
  always_comb begin
    reg_cnt_d = reg_cnt_q;
    dst_reg   = instr[RT_LSB +: REG_W];
    has_dst   = 1'b0;
    case (head_cls)
      CLS_R: begin
        dst_reg = instr[RD_LSB +: REG_W];
        has_dst = 1'b1;
      end
      CLS_I:   has_dst = 1'b1;
      default: has_dst = 1'b0;
    endcase
    if (fifo_pop && has_dst) begin
      for (int k = 0; k < 4; k++) begin
        if (dst_reg == REG_W'(k + 3)) reg_cnt_d[k] = reg_cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) reg_cnt_q <= '0;
    else     reg_cnt_q <= reg_cnt_d;
  end

  assign cnt_reg3 = reg_cnt_q[0];
  assign cnt_reg4 = reg_cnt_q[1];
  assign cnt_reg5 = reg_cnt_q[2];
  assign cnt_reg6 = reg_cnt_q[3];
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - vector table, corner sequences and random run against a queue model
module tb_mips_instr_encoder;

  localparam int CNT_W = 6;
  localparam int DEPTH = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_kind;
  logic [5:0]       req_op;
  logic [4:0]       req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]       req_funct;
  logic [15:0]      req_imm;
  logic [25:0]      req_target;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [CNT_W-1:0] cnt_r, cnt_i, cnt_j, err_cnt;
`ifdef ENC_REGUSE_EN
  logic [CNT_W-1:0] cnt_reg3, cnt_reg4, cnt_reg5, cnt_reg6;
`endif

  always #5 clk = ~clk;

  mips_instr_encoder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_op      (req_op),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_shamt   (req_shamt),
    .req_funct   (req_funct),
    .req_imm     (req_imm),
    .req_target  (req_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .cnt_r       (cnt_r),
    .cnt_i       (cnt_i),
    .cnt_j       (cnt_j),
    .err_cnt     (err_cnt)
`ifdef ENC_REGUSE_EN
    ,
    .cnt_reg3    (cnt_reg3),
    .cnt_reg4    (cnt_reg4),
    .cnt_reg5    (cnt_reg5),
    .cnt_reg6    (cnt_reg6)
`endif
  );

  typedef struct {
    logic [1:0]  kind;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  f;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
    bit          legal;
  } vec_t;

  vec_t vecs[10];

  int passed = 0;
  int total  = 0;
  int m_r, m_i, m_j, m_err;
  int m_reg[4];
  logic [31:0] mq[$];
  logic [31:0] bw[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_r = 0; m_i = 0; m_j = 0; m_err = 0;
    for (int k = 0; k < 4; k++) m_reg[k] = 0;
    mq.delete();
  endtask

  function automatic logic [31:0] model_encode(input logic [1:0] kind, input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] f, input logic [15:0] imm, input logic [25:0] tgt);
    int unsigned o, s, t, d, a;
    o = op; s = rs; t = rt; d = rd; a = sh;
    if (kind == 2'd0) return s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + a * 64 + f;
    if (kind == 2'd1) return o * (1 << 26) + s * (1 << 21) + t * (1 << 16) + imm;
    return o * (1 << 26) + tgt;
  endfunction

  function automatic bit model_legal(input logic [1:0] kind, input logic [5:0] op);
    if (kind == 2'd3) return 1'b0;
    if (kind == 2'd1) return !(op == 0 || op == 2 || op == 3);
    if (kind == 2'd2) return (op == 2 || op == 3);
    return 1'b1;
  endfunction

  task automatic model_pop(input logic [31:0] w);
    int unsigned op, dst;
    op = w / (1 << 26);
    if (op == 0) begin
      m_r++;
      dst = (w / (1 << 11)) % 32;
    end else if (op == 2 || op == 3) begin
      m_j++;
      dst = 0;
    end else begin
      m_i++;
      dst = (w / (1 << 16)) % 32;
    end
    if (dst >= 3 && dst <= 6) m_reg[dst - 3]++;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_cnt_r"},   32'(cnt_r),   32'(m_r % CMOD));
    chk({tag, "_cnt_i"},   32'(cnt_i),   32'(m_i % CMOD));
    chk({tag, "_cnt_j"},   32'(cnt_j),   32'(m_j % CMOD));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err % CMOD));
`ifdef ENC_REGUSE_EN
    chk({tag, "_cnt_reg3"}, 32'(cnt_reg3), 32'(m_reg[0] % CMOD));
    chk({tag, "_cnt_reg4"}, 32'(cnt_reg4), 32'(m_reg[1] % CMOD));
    chk({tag, "_cnt_reg5"}, 32'(cnt_reg5), 32'(m_reg[2] % CMOD));
    chk({tag, "_cnt_reg6"}, 32'(cnt_reg6), 32'(m_reg[3] % CMOD));
`endif
  endtask

  task automatic set_req(input logic [1:0] kind, input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] f,
      input logic [15:0] imm, input logic [25:0] tgt);
    req_valid = 1'b1;
    req_kind = kind; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = sh; req_funct = f; req_imm = imm; req_target = tgt;
  endtask

  task automatic clear_req();
    req_valid = 1'b0;
    req_kind = 2'd0; req_op = 6'd0; req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0;
    req_shamt = 5'd0; req_funct = 6'd0; req_imm = 16'd0; req_target = 26'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req();
    instr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    model_clear();
  endtask

  initial begin
    vecs[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0000000, 32'h00221820, 1'b1};
    vecs[1] = '{2'd1, 6'h08, 5'd1,  5'd4,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0000000, 32'h20240005, 1'b1};
    vecs[2] = '{2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h08000010, 1'b1};
    vecs[3] = '{2'd2, 6'h04, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h00000000, 1'b0};
    vecs[4] = '{2'd3, 6'h08, 5'd1,  5'd4,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0000000, 32'h00000000, 1'b0};
    vecs[5] = '{2'd1, 6'h00, 5'd1,  5'd4,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0000000, 32'h00000000, 1'b0};
    vecs[6] = '{2'd0, 6'h3f, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'h1234, 26'h0000000, 32'h03ffffff, 1'b1};
    vecs[7] = '{2'd2, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3ffffff, 32'h0fffffff, 1'b1};
    vecs[8] = '{2'd1, 6'h23, 5'd2,  5'd5,  5'd0,  5'd0,  6'h00, 16'hffff, 26'h0000000, 32'h8c45ffff, 1'b1};
    vecs[9] = '{2'd1, 6'h02, 5'd2,  5'd5,  5'd0,  5'd0,  6'h00, 16'hffff, 26'h0000000, 32'h00000000, 1'b0};

    // Reset state while rst is held high.
    rst = 1'b1;
    clear_req();
    instr_ready = 1'b0;
    step();
    step();
    model_clear();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    check_counters("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Vector table: one request, check the word, pop it, check counters.
    for (int v = 0; v < 10; v++) begin
      set_req(vecs[v].kind, vecs[v].op, vecs[v].rs, vecs[v].rt, vecs[v].rd, vecs[v].sh,
              vecs[v].f, vecs[v].imm, vecs[v].tgt);
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'd1);
      step();
      clear_req();
      if (!vecs[v].legal) m_err++;
      chk($sformatf("vec%0d_valid", v), 32'(instr_valid), 32'(vecs[v].legal));
      chk($sformatf("vec%0d_err_at_accept", v), 32'(err_cnt), 32'(m_err % CMOD));
      if (vecs[v].legal) chk($sformatf("vec%0d_instr", v), instr, vecs[v].exp);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      if (vecs[v].legal) model_pop(vecs[v].exp);
      chk($sformatf("vec%0d_empty", v), 32'(instr_valid), 32'd0);
      check_counters($sformatf("vec%0d", v));
    end

    // Backpressure: fill, no bypass while full-and-popping, then drain one per cycle.
    do_reset();
    for (int i = 0; i < 5; i++) bw[i] = model_encode(2'd0, 6'd0, 5'(i), 5'(i + 1), 5'(i + 7), 5'd0, 6'(i + 32), 16'd0, 26'd0);
    for (int i = 0; i < 4; i++) begin
      set_req(2'd0, 6'd0, 5'(i), 5'(i + 1), 5'(i + 7), 5'd0, 6'(i + 32), 16'd0, 26'd0);
      chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd1);
      step();
    end
    set_req(2'd0, 6'd0, 5'd4, 5'd5, 5'd11, 5'd0, 6'd36, 16'd0, 26'd0);
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    chk("bp_head0", instr, bw[0]);
    instr_ready = 1'b1;
    #1;
    chk("bp_no_bypass_ready", 32'(req_ready), 32'd0);
    step();
    model_pop(bw[0]);
    chk("bp_ready_after_pop", 32'(req_ready), 32'd1);
    chk("bp_head1", instr, bw[1]);
    step();
    model_pop(bw[1]);
    clear_req();
    for (int i = 2; i < 5; i++) begin
      chk($sformatf("bp_head%0d", i), instr, bw[i]);
      chk($sformatf("bp_valid%0d", i), 32'(instr_valid), 32'd1);
      step();
      model_pop(bw[i]);
    end
    chk("bp_drained", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;
    check_counters("bp");

    // Reset mid-stream with buffered words and nonzero counters.
    set_req(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    step();
    m_err++;
    for (int i = 0; i < 3; i++) begin
      set_req(2'd1, 6'h08, 5'd1, 5'(i + 3), 5'd0, 5'd0, 6'd0, 16'(i), 26'd0);
      step();
    end
    clear_req();
    chk("mid_valid_before", 32'(instr_valid), 32'd1);
    check_counters("mid_before");
    rst = 1'b1;
    instr_ready = 1'b1;
    set_req(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    model_clear();
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    check_counters("mid_rst");
    rst = 1'b0;
    clear_req();
    instr_ready = 1'b0;
    #1;
    chk("mid_rst_release_ready", 32'(req_ready), 32'd1);

    // Random traffic against the queue model; enough pops to wrap the counters.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [1:0]  k;
      logic [5:0]  op;
      logic [31:0] w;
      bit          acc, pp;
      k = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0: op = 6'd0;
          1: op = 6'd2;
          2: op = 6'd3;
          default: op = 6'd4;
        endcase
      end else begin
        op = 6'($urandom_range(0, 63));
      end
      set_req(k, op, 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
      req_valid   = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
      chk("rnd_valid", 32'(instr_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("rnd_instr", instr, mq[0]);
      check_counters("rnd");
      acc = req_valid && (mq.size() < DEPTH);
      pp  = instr_ready && (mq.size() > 0);
      if (pp) begin
        w = mq.pop_front();
        model_pop(w);
      end
      if (acc) begin
        if (model_legal(k, op))
          mq.push_back(model_encode(k, op, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm, req_target));
        else
          m_err++;
      end
      step();
    end
    clear_req();
    instr_ready = 1'b0;
    #1;
    check_counters("rnd_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Assembles MIPS instruction words (R/I/J formats) from field-level requests, buffers them in a small FIFO, and emits them on a valid/ready stream. It sits upstream of the instruction classifier/counter and acts as the generator side of that stream. It keeps its own per-class emit counters, with the same classification rules as the classifier, so the two can be cross-checked.

## Interface
- `CNT_W`, 6: width of every counter output.
- `DEPTH`, 4: output FIFO depth in words; must be a power of 2 and at least 2.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on `req_valid & req_ready`.
- `req_kind`  in  2  request format: 00 R, 01 I, 10 J, 11 reserved.
- `req_op`  in  6  opcode; ignored for R.
- `req_rs`, `req_rt`, `req_rd`, `req_shamt`  in  5 each  register and shift fields.
- `req_funct`  in  6  R-type function code.
- `req_imm`  in  16  I-type immediate.
- `req_target`  in  26  J-type target.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  downstream accepts on `instr_valid & instr_ready`.
- `instr`  out  32  FIFO head word.
- `cnt_r`, `cnt_i`, `cnt_j`  out  CNT_W each  emitted-word counts per class.
- `err_cnt`  out  CNT_W  count of dropped illegal requests.

## Operation
- Encoding by format:
  - R: {6'd0, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm}.
  - J: {op, target}.
- Illegal requests are accepted, then dropped with no FIFO push and `err_cnt` +1:
  - `req_kind` = 11.
  - I with op ∈ {0, 2, 3}.
  - J with op ∉ {2, 3}.
- `req_ready` = !rst && FIFO count < DEPTH. There is no bypass: when the FIFO is full, `req_ready` stays low even in a cycle that pops.
- Push and pop in the same cycle are allowed whenever not full. The count is unchanged and order is preserved.
- On each output handshake, the emitted word is classified by `instr[31:26]`:
  - 0 → `cnt_r` +1.
  - 2 or 3 → `cnt_j` +1.
  - otherwise → `cnt_i` +1.
- All counters wrap modulo 2^CNT_W.
- While `instr_valid` is high, `instr` is held stable until it is popped.

## Timing
- Reset values:
  - `req_ready` = 0 while `rst` is high.
  - `instr_valid` = 0, `instr` = 0.
  - All counters = 0.
  - FIFO pointers and count cleared.
- Reset mid-stream discards all buffered words. No counter increments in the reset cycle, even if a handshake is presented.
- Latency: a request accepted at edge N gives `instr_valid` = 1 with that word from edge N onward, i.e. one cycle later when the FIFO was empty.
- Throughput: one word per cycle with `instr_ready` held high.
- `err_cnt` updates at the accept edge. Class counters update at the pop edge.

## Configuration
- `ENC_REGUSE_EN` defined:
  - Adds outputs `cnt_reg3`, `cnt_reg4`, `cnt_reg5`, `cnt_reg6` (CNT_W each, reset 0).
  - Each counts popped words whose destination register (`instr[15:11]` for R, `instr[20:16]` for I) equals 3, 4, 5 or 6 respectively.
  - J words never count.
- `ENC_REGUSE_EN` undefined: these ports and counters do not exist.

## Structure
- Shared package holds:
  - Kind enum (`KIND_R`, `KIND_I`, `KIND_J`, `KIND_RSV`).
  - Opcode constants `OP_RTYPE` = 0, `OP_J` = 2, `OP_JAL` = 3.
  - Field position constants.
  - Classify function (word → class).
- One sub-module, `enc_fifo`: synchronous FIFO parameterized by width and DEPTH, with push/pop/full/empty/count.
- Encoder, legality check and counters live in the top.

## Test plan
- R request, rs=1 rt=2 rd=3 shamt=0 funct=0x20 → `instr` = 0x00221820 one cycle later; `cnt_r` = 1 after pop.
- I request, op=0x08 rs=1 rt=4 imm=0x0005 → `instr` = 0x20240005; `cnt_i` = 1. With `ENC_REGUSE_EN`, `cnt_reg4` = 1.
- J request, op=2 target=0x0000010 → `instr` = 0x08000010; `cnt_j` = 1.
- J request with op=4, then kind=11 → no `instr_valid`; `err_cnt` = 2; class counters stay 0.
- Hold `instr_ready` = 0 and push 5 requests → `req_ready` drops after the 4th; raise `instr_ready` → 4 words out in order, then the 5th accepted; 1 word per cycle.
- Assert `rst` with 3 words buffered and counters nonzero → next cycle `instr_valid` = 0, all counters 0; `req_ready` = 1 the cycle after `rst` deasserts.
